// File: rtl/shift_exec_seq.sv
// Execute-stage sequencer for MIPS shifts: latches the op, drives the external shifter bank, captures and holds the result.
// Optional feature: define SHIFT_VARIABLE_EN to accept sllv/srlv/srav (amount from rs_data[4:0]).
module shift_exec_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_shift,
  output logic [1:0]  sh_sel,
  input  logic [31:0] sh_res,
  input  logic        ack,
  output logic [31:0] alu_out,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       var_amt;
    logic [1:0] sel;
  } dec_t;

  localparam logic [1:0] SEL_SLL = 2'b00;
  localparam logic [1:0] SEL_SRL = 2'b01;
  localparam logic [1:0] SEL_SRA = 2'b10;

  function automatic dec_t decode_funct(input logic [5:0] f);
    dec_t d;
    d = '{legal: 1'b0, var_amt: 1'b0, sel: SEL_SLL};
    case (f)
      6'b000000: d = '{legal: 1'b1, var_amt: 1'b0, sel: SEL_SLL};
      6'b000010: d = '{legal: 1'b1, var_amt: 1'b0, sel: SEL_SRL};
      6'b000011: d = '{legal: 1'b1, var_amt: 1'b0, sel: SEL_SRA};
`ifdef SHIFT_VARIABLE_EN
      6'b000100: d = '{legal: 1'b1, var_amt: 1'b1, sel: SEL_SLL};
      6'b000110: d = '{legal: 1'b1, var_amt: 1'b1, sel: SEL_SRL};
      6'b000111: d = '{legal: 1'b1, var_amt: 1'b1, sel: SEL_SRA};
`endif
      default:   d = '{legal: 1'b0, var_amt: 1'b0, sel: SEL_SLL};
    endcase
    return d;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [4:0]  amt_q, amt_d;
  logic [1:0]  sel_q, sel_d;
  logic        ill_pend_q, ill_pend_d;
  logic [31:0] alu_q, alu_d;
  logic        illegal_q, illegal_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  dec_t        dec_s;
  logic [4:0]  amt_sel_s;

  assign dec_s = decode_funct(funct);

`ifdef SHIFT_VARIABLE_EN
  logic unused_rs_s;
  assign unused_rs_s = ^rs_data[31:5];
  assign amt_sel_s   = dec_s.var_amt ? rs_data[4:0] : shamt;
`else
  logic unused_rs_s;
  assign unused_rs_s = (^rs_data) ^ dec_s.var_amt;
  assign amt_sel_s   = shamt;
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    amt_d      = amt_q;
    sel_d      = sel_q;
    ill_pend_d = ill_pend_q;
    alu_d      = alu_q;
    illegal_d  = illegal_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d       = rt_data;
          amt_d      = amt_sel_s;
          sel_d      = dec_s.sel;
          ill_pend_d = ~dec_s.legal;
          state_d    = ST_EXEC;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end else begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b0;
        end
      end
      ST_EXEC: begin
        // Shifter lines are zeroed once the result is taken so they idle at 0.
        if (ill_pend_q) begin
          illegal_d = 1'b1;
        end else begin
          alu_d     = sh_res;
        end
        op_d       = 32'd0;
        amt_d      = 5'd0;
        sel_d      = SEL_SLL;
        ill_pend_d = 1'b0;
        state_d    = ST_DONE;
        busy_d     = 1'b1;
        done_d     = 1'b1;
      end
      ST_DONE: begin
        if (ack) begin
          state_d   = ST_IDLE;
          illegal_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b0;
        end else begin
          state_d   = ST_DONE;
          busy_d    = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        op_d       = 32'd0;
        amt_d      = 5'd0;
        sel_d      = SEL_SLL;
        ill_pend_d = 1'b0;
        illegal_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 32'd0;
      amt_q      <= 5'd0;
      sel_q      <= SEL_SLL;
      ill_pend_q <= 1'b0;
      alu_q      <= 32'd0;
      illegal_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      amt_q      <= amt_d;
      sel_q      <= sel_d;
      ill_pend_q <= ill_pend_d;
      alu_q      <= alu_d;
      illegal_q  <= illegal_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sh_a     = op_q;
  assign sh_shift = amt_q;
  assign sh_sel   = sel_q;
  assign alu_out  = alu_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_shift_exec_seq.sv
// Directed bench for shift_exec_seq; models the external shifter bank and checks hand-computed results.
module tb_shift_exec_seq;
  logic        clk = 1'b0;
  logic        rst, start, ack;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_data, rt_data, sh_a, sh_res, alu_out;
  logic [4:0]  sh_shift;
  logic [1:0]  sh_sel;
  logic        busy, done, illegal;
  int vectors = 0;
  int miscompares = 0;

  shift_exec_seq dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .shamt(shamt),
    .rs_data(rs_data), .rt_data(rt_data), .sh_a(sh_a), .sh_shift(sh_shift),
    .sh_sel(sh_sel), .sh_res(sh_res), .ack(ack), .alu_out(alu_out),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // External combinational shifter bank
  always_comb begin
    case (sh_sel)
      2'b00:   sh_res = sh_a << sh_shift;
      2'b01:   sh_res = sh_a >> sh_shift;
      2'b10:   sh_res = $unsigned($signed(sh_a) >>> sh_shift);
      default: sh_res = 32'hDEAD_BEEF;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] f, input logic [4:0] sa,
                        input logic [31:0] rs, input logic [31:0] rt);
    funct = f; shamt = sa; rs_data = rs; rt_data = rt;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    set_op(6'd0, 5'd0, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if ({alu_out, busy, done, illegal} !== {32'd0, 3'b000}) begin
      $display("FAIL reset_out: got alu=%h b/d/i=%b%b%b want 0/000", alu_out, busy, done, illegal);
      miscompares++;
    end
    vectors++;
    if ({sh_a, sh_shift, sh_sel} !== 39'd0) begin
      $display("FAIL reset_sh: got sh_a=%h shift=%0d sel=%b want 0", sh_a, sh_shift, sh_sel);
      miscompares++;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL ack_in_idle: got busy=%b done=%b want 00", busy, done);
      miscompares++;
    end
  endtask

  task automatic test_srl();
    set_op(6'b000010, 5'd4, 32'd0, 32'h8000_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({sh_sel, sh_shift, sh_a} !== {2'b01, 5'd4, 32'h8000_0000}) begin
      $display("FAIL srl_exec_drive: got sel=%b shift=%0d a=%h want 01/4/80000000", sh_sel, sh_shift, sh_a);
      miscompares++;
    end
    vectors++;
    if ({busy, done} !== 2'b10) begin
      $display("FAIL srl_exec_flags: got busy=%b done=%b want 10", busy, done);
      miscompares++;
    end
    tick();
    vectors++;
    if ({alu_out, done, illegal} !== {32'h0800_0000, 2'b10}) begin
      $display("FAIL srl_done: got alu=%h done=%b ill=%b want 08000000/1/0", alu_out, done, illegal);
      miscompares++;
    end
    vectors++;
    if ({sh_a, sh_shift, sh_sel} !== 39'd0) begin
      $display("FAIL srl_sh_idle: got sh_a=%h shift=%0d sel=%b want 0", sh_a, sh_shift, sh_sel);
      miscompares++;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL srl_ack: got busy=%b done=%b want 00", busy, done);
      miscompares++;
    end
  endtask

  task automatic test_sra_sll();
    set_op(6'b000011, 5'd31, 32'd0, 32'h8000_0000);
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (sh_sel !== 2'b10) begin
      $display("FAIL sra_sel: got %b want 10", sh_sel);
      miscompares++;
    end
    tick();
    vectors++;
    if (alu_out !== 32'hFFFF_FFFF) begin
      $display("FAIL sra_result: got %h want ffffffff", alu_out);
      miscompares++;
    end
    ack = 1'b1; tick(); ack = 1'b0;
    set_op(6'b000000, 5'd0, 32'd0, 32'h0000_0001);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    vectors++;
    if ({alu_out, done} !== {32'h0000_0001, 1'b1}) begin
      $display("FAIL sll_zero: got alu=%h done=%b want 00000001/1", alu_out, done);
      miscompares++;
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_variable();
    set_op(6'b000110, 5'd9, 32'hFFFF_FFE3, 32'h0000_00F0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
`ifdef SHIFT_VARIABLE_EN
    vectors++;
    if ({alu_out, done, illegal} !== {32'h0000_001E, 2'b10}) begin
      $display("FAIL srlv: got alu=%h done=%b ill=%b want 0000001e/1/0", alu_out, done, illegal);
      miscompares++;
    end
`else
    vectors++;
    if ({alu_out, done, illegal} !== {32'h0000_0001, 2'b11}) begin
      $display("FAIL srlv_disabled: got alu=%h done=%b ill=%b want 00000001/1/1", alu_out, done, illegal);
      miscompares++;
    end
`endif
    ack = 1'b1; tick(); ack = 1'b0;
    vectors++;
    if ({illegal, busy} !== 2'b00) begin
      $display("FAIL srlv_clear: got ill=%b busy=%b want 00", illegal, busy);
      miscompares++;
    end
  endtask

  task automatic test_ignore_and_hold();
    set_op(6'b000000, 5'd4, 32'd0, 32'h0000_000F);
    start = 1'b1; tick();
    // start and ack while in EXEC, with different operands presented
    set_op(6'b000010, 5'd1, 32'd0, 32'hFFFF_FFFF);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if ({alu_out, done} !== {32'h0000_00F0, 1'b1}) begin
      $display("FAIL exec_ignore: got alu=%h done=%b want 000000f0/1", alu_out, done);
      miscompares++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({alu_out, done, busy} !== {32'h0000_00F0, 2'b11}) begin
        $display("FAIL done_hold%0d: got alu=%h done=%b busy=%b want 000000f0/1/1", i, alu_out, done, busy);
        miscompares++;
      end
    end
    start = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    set_op(6'b000011, 5'd4, 32'd0, 32'hF000_0000);
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if ({busy, done, sh_a} !== {2'b10, 32'hF000_0000}) begin
      $display("FAIL start_after_ack: got busy=%b done=%b a=%h want 1/0/f0000000", busy, done, sh_a);
      miscompares++;
    end
    tick();
    vectors++;
    if (alu_out !== 32'hFF00_0000) begin
      $display("FAIL start_after_ack_res: got %h want ff000000", alu_out);
      miscompares++;
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_illegal();
    set_op(6'h20, 5'd3, 32'd0, 32'h1234_5678);
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (sh_sel === 2'b11) begin
      $display("FAIL illegal_sel: got %b want not 11", sh_sel);
      miscompares++;
    end
    tick();
    vectors++;
    if ({alu_out, done, illegal} !== {32'hFF00_0000, 2'b11}) begin
      $display("FAIL illegal_done: got alu=%h done=%b ill=%b want ff000000/1/1", alu_out, done, illegal);
      miscompares++;
    end
    ack = 1'b1; tick(); ack = 1'b0;
    vectors++;
    if ({illegal, done, alu_out} !== {2'b00, 32'hFF00_0000}) begin
      $display("FAIL illegal_clear: got ill=%b done=%b alu=%h want 0/0/ff000000", illegal, done, alu_out);
      miscompares++;
    end
  endtask

  task automatic test_rst_exec();
    set_op(6'b000010, 5'd8, 32'd0, 32'h1234_5678);
    start = 1'b1; tick(); start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++;
    if ({alu_out, busy, done, illegal, sh_a, sh_shift, sh_sel} !== 74'd0) begin
      $display("FAIL rst_exec: got alu=%h b/d/i=%b%b%b a=%h want all 0", alu_out, busy, done, illegal, sh_a);
      miscompares++;
    end
    tick();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL rst_no_done: got busy=%b done=%b want 00", busy, done);
      miscompares++;
    end
    set_op(6'b000000, 5'd8, 32'd0, 32'h1234_5678);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    vectors++;
    if ({alu_out, done} !== {32'h3456_7800, 1'b1}) begin
      $display("FAIL rst_recover: got alu=%h done=%b want 34567800/1", alu_out, done);
      miscompares++;
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_op(6'b000011, 5'd4, 32'd0, 32'h8000_0010);
    start = 1'b1; ack = 1'b1;
    tick();
    set_op(6'b000010, 5'd8, 32'd0, 32'h0000_FF00);
    tick();
    vectors++;
    if ({alu_out, done} !== {32'hF800_0001, 1'b1}) begin
      $display("FAIL b2b_op1: got alu=%h done=%b want f8000001/1", alu_out, done);
      miscompares++;
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL b2b_idle: got busy=%b want 0", busy);
      miscompares++;
    end
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if ({alu_out, done} !== {32'h0000_00FF, 1'b1}) begin
      $display("FAIL b2b_op2: got alu=%h done=%b want 000000ff/1", alu_out, done);
      miscompares++;
    end
    tick();
    ack = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL b2b_end: got busy=%b done=%b want 00", busy, done);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_srl();
    test_sra_sll();
    test_variable();
    test_ignore_and_hold();
    test_illegal();
    test_rst_exec();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/shift_exec_seq.md
# shift_exec_seq

Execute-stage sequencer for MIPS shift instructions in the multi-cycle SoC. It latches the decoded shift operation and operands on a start strobe and drives the operand, amount and select lines into the combinational shifter bank (sll/srl/sra). It then captures the returned shifter result into a registered ALU-out value and holds it under a done/ack handshake with the multi-cycle controller.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe; honoured only in IDLE
- funct  in  6  MIPS funct: 000000 sll, 000010 srl, 000011 sra, 000100 sllv, 000110 srlv, 000111 srav
- shamt  in  5  instruction shift amount, used by sll/srl/sra
- rs_data  in  32  register rs; bits [4:0] are the amount for variable forms
- rt_data  in  32  register rt; the operand being shifted
- sh_a  out  32  operand to the shifter bank
- sh_shift  out  5  shift amount to the shifter bank
- sh_sel  out  2  shifter select: 00 sll, 01 srl, 10 sra; 11 is never driven
- sh_res  in  32  selected shifter result, combinational from sh_a, sh_shift and sh_sel
- ack  in  1  controller consumed the result
- alu_out  out  32  registered result
- busy  out  1  high in any state other than IDLE
- done  out  1  high only in DONE
- illegal  out  1  funct unsupported; valid while done

## Operation
- FSM states:
  - IDLE: wait for start.
  - EXEC: drive the shifter bank, then capture the result.
  - DONE: hold the result until ack.
- IDLE, start=1:
  - Latch rt_data into an operand register.
  - Latch the amount: shamt for fixed forms, rs_data[4:0] for variable forms. Ignore rs_data[31:5].
  - Latch sel and an illegal flag from funct.
  - Next state is EXEC.
- IDLE, start=0: stay in IDLE.
- EXEC:
  - sh_a, sh_shift and sh_sel come from the latched registers.
  - At the next edge, alu_out<=sh_res if the op is legal. If illegal, alu_out holds its old value and illegal<=1.
  - Next state is DONE.
- DONE:
  - done=1, and alu_out is stable.
  - If ack=1, go to IDLE and clear illegal at that edge. Otherwise stay in DONE.
- start is ignored in EXEC and DONE; there is no queueing.
- ack outside DONE is ignored.
- In IDLE, sh_a, sh_shift and sh_sel are driven to 0.
- Amount 0 is legal: alu_out=rt_data.
- Any funct not in the list is illegal.

## Timing
- Reset values: state IDLE; alu_out=0, busy=0, done=0, illegal=0, sh_a=0, sh_shift=0, sh_sel=00.
- rst wins over every other input on the same edge. Reset in EXEC or DONE aborts the operation, and no done is produced.
- Latency: start sampled at edge k → EXEC after k. Result is captured at k+1; done=1 from k+1.
- ack sampled at edge k+1 is too early because state is still EXEC and ack is ignored. Earliest ack is at edge k+2, which returns to IDLE.
- A new start is accepted no earlier than the edge after return to IDLE. Back-to-back throughput is one op per 3 cycles, with ack held high.
- Shifter path: sh_res must settle within one clk period of EXEC entry.
- busy, done and illegal are decoded from registered state; they are glitch-free.

## Configuration
- SHIFT_VARIABLE_EN defined:
  - sllv, srlv and srav are legal.
  - The amount comes from rs_data[4:0].
- SHIFT_VARIABLE_EN undefined:
  - Funct 000100, 000110 and 000111 are illegal.
  - They complete via DONE with illegal=1, and alu_out is unchanged.
  - rs_data is unused.

## Test plan
- Reset, then srl with rt=0x80000000, shamt=4, start at edge 0. Expect sh_sel=01 and sh_shift=4 in EXEC. Expect alu_out=0x08000000 and done=1 after edge 1. Ack at edge 2 gives busy=0.
- sra with rt=0x80000000, shamt=31 → alu_out=0xFFFFFFFF. Then sll with rt=0x00000001, shamt=0 → alu_out=0x00000001.
- srlv with rs=0xFFFFFFE3 (amount 3), rt=0x000000F0:
  - With SHIFT_VARIABLE_EN: alu_out=0x0000001E.
  - Without it: illegal=1 with done, and alu_out keeps its prior value.
- Start pulses in EXEC and in DONE are ignored. ack held low for 5 cycles: done stays 1 and alu_out is stable. A start in the IDLE cycle after ack is accepted.
- Illegal funct 0x20 → done=1, illegal=1, alu_out unchanged. illegal clears on the ack edge.
- rst asserted during EXEC → next cycle all outputs are at reset values, with no done pulse. A subsequent start completes normally.
